binary_to_gray_counter: RTL

Registered binary counter that drives a matching Gray-code output, producing single-bit-change pointers for multi-clock FIFOs and position encoders. It is the encode side of the team's Gray-to-binary conversion: its `gray_out` is what downstream logic decodes back to binary. Both codes are registered in the same cycle, so `gray_out` is glitch-free and safe to hand to a synchronizer.

---
 rtl/binary_to_gray_counter_if.sv | 24 ++
 rtl/binary_to_gray_counter.sv | 68 ++++++
 2 files changed

// File: rtl/binary_to_gray_counter_if.sv
// Control and output bundle for binary_to_gray_counter.
// The dir signal exists only when GRAY_CNT_DOWN_EN is defined.
interface binary_to_gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_bin;
`ifdef GRAY_CNT_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;
    logic             gray_vld;

`ifdef GRAY_CNT_DOWN_EN
    modport master (output en, load, load_bin, dir, input bin_out, gray_out, tc, gray_vld);
    modport slave  (input en, load, load_bin, dir, output bin_out, gray_out, tc, gray_vld);
`else
    modport master (output en, load, load_bin, input bin_out, gray_out, tc, gray_vld);
    modport slave  (input en, load, load_bin, output bin_out, gray_out, tc, gray_vld);
`endif
endinterface

// File: rtl/binary_to_gray_counter.sv
// Registered binary counter with a matching registered Gray-code output.
// Define GRAY_CNT_DOWN_EN to build the dir input and down-counting.
module binary_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    binary_to_gray_counter_if.slave     bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc_q;
    logic             vld_q;
    logic [WIDTH-1:0] bin_d;
    logic             tc_d;
    logic             accept;

    // gray_vld has no ready partner: it pulses for exactly one cycle after
    // every edge that accepted a load or a step, whether or not the value moved.
    assign accept = bus.load | bus.en;

    always_comb begin
        bin_d = bin_q;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en) begin
`ifdef GRAY_CNT_DOWN_EN
            bin_d = bus.dir ? (bin_q + ONE) : (bin_q - ONE);
`else
            bin_d = bin_q + ONE;
`endif
        end
    end

`ifdef GRAY_CNT_DOWN_EN
    assign tc_d = bus.dir ? (&bin_d) : ~(|bin_d);
`else
    assign tc_d = &bin_d;
`endif

    // Gray is derived from the next binary value so both registers agree every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            vld_q  <= 1'b0;
`ifdef GRAY_CNT_DOWN_EN
            tc_q   <= ~bus.dir;
`else
            tc_q   <= 1'b0;
`endif
        end else begin
            vld_q <= accept;
            if (accept) begin
                bin_q  <= bin_d;
                gray_q <= bin_d ^ (bin_d >> 1);
                tc_q   <= tc_d;
            end
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.tc       = tc_q;
    assign bus.gray_vld = vld_q;
endmodule
